// File: rtl/freq_duty_meter.sv
// Period / high-time meter for a divided clock sampled in the clk_in domain, with A/B setting classification.
// Optional duty-cycle divider enabled by defining DUTY_PCT_EN (adds duty_pct / duty_valid).
module freq_duty_meter #(
  parameter int CNT_W    = 16,
  parameter int PERIOD_A = 28121,
  parameter int HIGH_A   = 5625,
  parameter int PERIOD_B = 4245,
  parameter int HIGH_B   = 849,
  parameter int TOL      = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic [1:0]       mode_out,
  output logic             timeout
`ifdef DUTY_PCT_EN
  ,
  output logic [6:0]       duty_pct,
  output logic             duty_valid
`endif
);

  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic [CNT_W-1:0]        PA      = CNT_W'(PERIOD_A);
  localparam logic [CNT_W-1:0]        HA      = CNT_W'(HIGH_A);
  localparam logic [CNT_W-1:0]        PB      = CNT_W'(PERIOD_B);
  localparam logic [CNT_W-1:0]        HB      = CNT_W'(HIGH_B);
  localparam logic signed [CNT_W:0]   TOL_S   = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             high_run;
  logic [CNT_W-1:0] meas_high;
  logic [1:0]       mode_next;
  logic             meas_hit;

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign meas_hit  = rise && (state != IDLE);
  assign meas_high = high_run ? period_cnt : high_cnt;

  function automatic logic near(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] r);
    logic signed [CNT_W:0] d;
    d = $signed({1'b0, v}) - $signed({1'b0, r});
    return (d <= TOL_S) && (d >= -TOL_S);
  endfunction

  always_comb begin
    mode_next = 2'b00;
    if (near(period_cnt, PA) && near(meas_high, HA))      mode_next = 2'b01;
    else if (near(period_cnt, PB) && near(meas_high, HB)) mode_next = 2'b10;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      high_run   <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      mode_out   <= 2'b00;
      timeout    <= 1'b0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state      <= ARM;
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
            high_run   <= 1'b1;
          end
        end
        ARM, MEAS: begin
          if (rise) begin
            period_out <= period_cnt;
            high_out   <= meas_high;
            mode_out   <= mode_next;
            meas_valid <= 1'b1;
            timeout    <= 1'b0;
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
            high_run   <= 1'b1;
            state      <= MEAS;
          end else if (period_cnt == CNT_MAX) begin
            // Counters park at full scale until the next rise re-arms.
            state    <= IDLE;
            timeout  <= 1'b1;
            high_run <= 1'b0;
          end else begin
            period_cnt <= period_cnt + 1'b1;
            if (high_run) begin
              if (fall) high_run <= 1'b0;
              else      high_cnt <= high_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DUTY_PCT_EN
  localparam int DW = CNT_W + 7;
  localparam int IW = $clog2(DW + 1);

  logic [DW-1:0]    quo;
  logic [CNT_W:0]   rem;
  logic [CNT_W-1:0] dsor;
  logic [IW-1:0]    iter;
  logic             busy;
  logic [CNT_W:0]   trial;
  logic             ge;
  logic [DW-1:0]    dividend;

  assign dividend = DW'(meas_high) * DW'(7'd100);
  assign trial    = {rem[CNT_W-1:0], quo[DW-1]};
  assign ge       = trial >= {1'b0, dsor};

  // Division starts alongside the result latch, so a new measurement always restarts it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      quo        <= '0;
      rem        <= '0;
      dsor       <= '0;
      iter       <= '0;
      busy       <= 1'b0;
      duty_pct   <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (meas_hit) begin
        quo  <= dividend;
        rem  <= '0;
        dsor <= period_cnt;
        iter <= IW'(DW);
        busy <= 1'b1;
      end else if (busy) begin
        rem  <= ge ? trial - {1'b0, dsor} : trial;
        quo  <= {quo[DW-2:0], ge};
        iter <= iter - 1'b1;
        if (iter == IW'(1)) begin
          busy       <= 1'b0;
          duty_valid <= 1'b1;
          duty_pct   <= (dsor == '0) ? 7'd0 : {quo[5:0], ge};
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_duty_meter.sv
// Bench for freq_duty_meter: table-driven vectors on a full-size instance, random segments on a narrow instance.
module tb_freq_duty_meter;

  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_m = 1'b0, sig_s = 1'b0;

  logic [15:0]   per_m, hi_m;
  logic          mv_m, to_m;
  logic [1:0]    mode_m;
  logic [SW-1:0] per_s, hi_s;
  logic          mv_s, to_s;
  logic [1:0]    mode_s;
`ifdef DUTY_PCT_EN
  logic [6:0]    duty_m, duty_s;
  logic          dv_m, dv_s;
`endif

  always #5 clk = ~clk;

  freq_duty_meter u_main (
    .clk_in(clk), .rst(rst), .sig_in(sig_m),
    .period_out(per_m), .high_out(hi_m), .meas_valid(mv_m),
    .mode_out(mode_m), .timeout(to_m)
`ifdef DUTY_PCT_EN
    , .duty_pct(duty_m), .duty_valid(dv_m)
`endif
  );

  freq_duty_meter #(
    .CNT_W(SW), .PERIOD_A(40), .HIGH_A(10), .PERIOD_B(20), .HIGH_B(5), .TOL(2)
  ) u_small (
    .clk_in(clk), .rst(rst), .sig_in(sig_s),
    .period_out(per_s), .high_out(hi_s), .meas_valid(mv_s),
    .mode_out(mode_s), .timeout(to_s)
`ifdef DUTY_PCT_EN
    , .duty_pct(duty_s), .duty_valid(dv_s)
`endif
  );

  typedef struct {
    int         p;
    int         h;
    logic [1:0] m;
  } exp_t;

  typedef struct {
    int         high;
    int         low;
    int         p;
    int         h;
    logic [1:0] m;
  } vec_t;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t pend[2];
  bit   pend_v[2];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Reference: a measurement is the (period, high) of the segment closed by a rise,
  // reported only if the meter was armed and the period fits the counter.
  function automatic void model_exp(input int d, input int h, input int l,
                                    output exp_t e, output bit v);
    int pa, ha, pb, hb, maxp, p;
    pa = (d == 0) ? 28121 : 40;
    ha = (d == 0) ? 5625  : 10;
    pb = (d == 0) ? 4245  : 20;
    hb = (d == 0) ? 849   : 5;
    maxp = (d == 0) ? 65535 : 255;
    p = h + l;
    e.p = p;
    e.h = h;
    if (iabs(p - pa) <= 2 && iabs(h - ha) <= 2)      e.m = 2'b01;
    else if (iabs(p - pb) <= 2 && iabs(h - hb) <= 2) e.m = 2'b10;
    else                                              e.m = 2'b00;
    v = (p <= maxp);
  endfunction

  task automatic set_sig(input int d, input logic val);
    if (d == 0) sig_m = val;
    else        sig_s = val;
  endtask

  task automatic close_seg(input int d);
    if (pend_v[d]) begin
      if (d == 0) q_m.push_back(pend[d]);
      else        q_s.push_back(pend[d]);
    end
    pend_v[d] = 1'b0;
  endtask

  task automatic drive_seg(input int d, input int h, input int l, input exp_t e, input bit ev);
    close_seg(d);
    pend[d]   = e;
    pend_v[d] = ev;
    set_sig(d, 1'b1);
    repeat (h) @(negedge clk);
    set_sig(d, 1'b0);
    repeat (l) @(negedge clk);
  endtask

  task automatic model_seg(input int d, input int h, input int l);
    exp_t e;
    bit   v;
    model_exp(d, h, l, e, v);
    drive_seg(d, h, l, e, v);
  endtask

  task automatic final_rise(input int d);
    close_seg(d);
    set_sig(d, 1'b1);
    repeat (12) @(negedge clk);
  endtask

`ifdef DUTY_PCT_EN
  int exp_duty_m = 0, exp_duty_s = 0;
`endif

  always @(negedge clk) begin : mon_m
    exp_t e;
`ifdef DUTY_PCT_EN
    if (dv_m) chk("main_duty", 32'(duty_m), 32'(exp_duty_m));
`endif
    if (mv_m) begin
      if (q_m.size() == 0) begin
        checks++; errors++;
        $display("FAIL main_unexpected_valid: got period %0d high %0d expected no valid", per_m, hi_m);
      end else begin
        e = q_m.pop_front();
        chk("main_period", 32'(per_m), 32'(e.p));
        chk("main_high", 32'(hi_m), 32'(e.h));
        chk("main_mode", 32'(mode_m), 32'(e.m));
        chk("main_timeout_clear", 32'(to_m), 0);
`ifdef DUTY_PCT_EN
        exp_duty_m = e.h * 100 / e.p;
`endif
      end
    end
  end

  always @(negedge clk) begin : mon_s
    exp_t e;
`ifdef DUTY_PCT_EN
    if (dv_s) chk("small_duty", 32'(duty_s), 32'(exp_duty_s));
`endif
    if (mv_s) begin
      if (q_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL small_unexpected_valid: got period %0d high %0d expected no valid", per_s, hi_s);
      end else begin
        e = q_s.pop_front();
        chk("small_period", 32'(per_s), 32'(e.p));
        chk("small_high", 32'(hi_s), 32'(e.h));
        chk("small_mode", 32'(mode_s), 32'(e.m));
        chk("small_timeout_clear", 32'(to_s), 0);
`ifdef DUTY_PCT_EN
        exp_duty_s = e.h * 100 / e.p;
`endif
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin : stim
    vec_t tbl[6];
    int   h, l, r;

    tbl[0] = '{5625, 22496, 28121, 5625, 2'b01};
    tbl[1] = '{849,  3396,  4245,  849,  2'b10};
    tbl[2] = '{849,  3398,  4247,  849,  2'b10};
    tbl[3] = '{849,  3399,  4248,  849,  2'b00};
    tbl[4] = '{5625, 1000,  6625,  5625, 2'b00};
    tbl[5] = '{849,  3396,  4245,  849,  2'b10};

    repeat (3) @(negedge clk);
    chk("reset_period", 32'(per_m), 0);
    chk("reset_high", 32'(hi_m), 0);
    chk("reset_valid", 32'(mv_m), 0);
    chk("reset_mode", 32'(mode_m), 0);
    chk("reset_timeout", 32'(to_m), 0);
    chk("reset_small_period", 32'(per_s), 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a measurement.
    model_seg(0, 20, 50);
    model_seg(0, 20, 50);
    model_seg(0, 20, 10);
    chk("pre_reset_period", 32'(per_m), 70);
    #2 rst = 1'b1;
    #1;
    chk("midreset_period", 32'(per_m), 0);
    chk("midreset_high", 32'(hi_m), 0);
    chk("midreset_mode", 32'(mode_m), 0);
    chk("midreset_timeout", 32'(to_m), 0);
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_queue_drained", 32'(q_m.size()), 0);

    for (int i = 0; i < 6; i++)
      drive_seg(0, tbl[i].high, tbl[i].low, '{tbl[i].p, tbl[i].h, tbl[i].m}, 1'b1);
    final_rise(0);
    chk("main_all_valids_seen", 32'(q_m.size()), 0);

    // Narrow instance: timeout and period boundary at 2^8-1.
    model_seg(1, 10, 30);
    model_seg(1, 10, 30);
    model_seg(1, 10, 280);
    chk("timeout_set", 32'(to_s), 1);
    chk("timeout_hold_period", 32'(per_s), 40);
    chk("timeout_hold_high", 32'(hi_s), 10);
    chk("timeout_hold_mode", 32'(mode_s), 1);
    model_seg(1, 5, 15);
    model_seg(1, 5, 15);
    model_seg(1, 10, 245);
    model_seg(1, 10, 246);
    model_seg(1, 5, 15);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 2) begin
        h = 7 + int'($urandom_range(0, 6));
        l = 37 + int'($urandom_range(0, 6)) - h;
      end else if (r <= 5) begin
        h = 3 + int'($urandom_range(0, 4));
        l = 17 + int'($urandom_range(0, 6)) - h;
      end else if (r <= 8) begin
        h = 1 + int'($urandom_range(0, 99));
        l = 1 + int'($urandom_range(0, 99));
      end else begin
        h = 1 + int'($urandom_range(0, 19));
        l = 230 + int'($urandom_range(0, 20));
      end
      model_seg(1, h, l);
    end
    final_rise(1);
    chk("small_all_valids_seen", 32'(q_s.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
